// File: rtl/fetch_buffer_pkg.sv
// Shared constants for the instruction fetch buffer: NOP encoding,
// exception code width and the packed per-entry width.
package fetch_buffer_pkg;

  // Instruction substituted for a faulting fetch so decode sees a harmless op.
  localparam logic [31:0] NOP_INST = 32'h0340_0000;

  // Width of the icache exception code.
  localparam int EXC_W = 7;

  // Packed entry layout, MSB first: {inst[31:0], pc[31:0], cookie, exc, badv[31:0]}.
  function automatic int entry_width(input int cookie_w);
    return 32 + 32 + cookie_w + EXC_W + 32;
  endfunction

endpackage

// File: rtl/fetch_buffer_ram.sv
// Entry storage for the fetch buffer: two write ports at consecutive
// addresses (so one fetch group lands in one cycle) and two asynchronous
// read ports for the two decode slots. Contents are not reset.
module fetch_buffer_ram #(
  parameter int DEPTH   = 8,
  parameter int ENTRY_W = 135,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we0,
  input  logic               we1,
  input  logic [PTR_W-1:0]   waddr,
  input  logic [ENTRY_W-1:0] wdata0,
  input  logic [ENTRY_W-1:0] wdata1,
  input  logic [PTR_W-1:0]   raddr0,
  input  logic [PTR_W-1:0]   raddr1,
  output logic [ENTRY_W-1:0] rdata0,
  output logic [ENTRY_W-1:0] rdata1
);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   waddr1;

  // Second write lands one slot later; pointer width makes it wrap naturally.
  assign waddr1 = waddr + PTR_W'(1);

  // Write both ports; port 1 is written last so it wins on an address clash.
  always_ff @(posedge clk) begin
    if (we0) mem[waddr]  <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch queue behind the icache. Splits each 64-bit fetch group
// into one or two instruction entries, presents the two oldest entries to
// decode and gives the PC stage a credit-style ready so that icache returns,
// which cannot be stalled, always find room.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int COOKIE_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic [63:0]             in_data,
  input  logic [31:0]             in_pc,
  input  logic [COOKIE_WIDTH-1:0] in_cookie,
  input  logic [EXC_W-1:0]        in_exception,
  input  logic [31:0]             in_badv,
  output logic                    fetch_ready,
  output logic [1:0]              out_valid,
  output logic [31:0]             out_inst0,
  output logic [31:0]             out_inst1,
  output logic [31:0]             out_pc0,
  output logic [31:0]             out_pc1,
  output logic [COOKIE_WIDTH-1:0] out_cookie0,
  output logic [COOKIE_WIDTH-1:0] out_cookie1,
  output logic [EXC_W-1:0]        out_exc0,
  output logic [EXC_W-1:0]        out_exc1,
  output logic [31:0]             out_badv0,
  output logic [31:0]             out_badv1,
  input  logic [1:0]              dec_pop,
  output logic                    overflow
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = entry_width(COOKIE_WIDTH);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  ptr_t               head;
  ptr_t               tail;
  cnt_t               count;
  cnt_t               push_n;
  cnt_t               space;
  cnt_t               accept_n;
  logic               drop;
  logic [1:0]         avail_n;
  logic [1:0]         pop_n;
  logic               we0;
  logic               we1;
  logic [ENTRY_W-1:0] entry0;
  logic [ENTRY_W-1:0] entry1;
  logic [ENTRY_W-1:0] rd0;
  logic [ENTRY_W-1:0] rd1;

  // Split the returning fetch group into the entries it contributes.
  always_comb begin
    push_n = '0;
    entry0 = {in_data[31:0], in_pc, in_cookie, in_exception, in_badv};
    entry1 = {in_data[63:32], in_pc + 32'd4, in_cookie, in_exception, in_badv};
    if (in_valid) begin
      if (in_exception != '0) begin
        // A faulting fetch becomes a single NOP carrying the fault details.
        push_n = cnt_t'(1);
        entry0 = {NOP_INST, in_pc, in_cookie, in_exception, in_badv};
      end else if (in_pc[2]) begin
        // Fetch started at the upper word: only that word is a real instruction.
        push_n = cnt_t'(1);
        entry0 = {in_data[63:32], in_pc, in_cookie, in_exception, in_badv};
      end else begin
        push_n = cnt_t'(2);
      end
    end
  end

  // Room is judged against the occupancy before this cycle's pop.
  assign space    = DEPTH_C - count;
  assign drop     = push_n > space;
  assign accept_n = drop ? space : push_n;
  assign we0      = !flush && (accept_n >= cnt_t'(1));
  assign we1      = !flush && (accept_n >= cnt_t'(2));

  // Two free groups of two entries cover both requests that may be in flight.
  assign fetch_ready = space >= cnt_t'(4);

  // An exception entry at the head always issues alone.
  assign out_valid[0] = count >= cnt_t'(1);
  assign out_valid[1] = (count >= cnt_t'(2)) && (out_exc0 == '0);

  // Decode may ask for more than is offered; clip to what is valid.
  assign avail_n = {1'b0, out_valid[0]} + {1'b0, out_valid[1]};
  assign pop_n   = (dec_pop > avail_n) ? avail_n : dec_pop;

  // Pointer and occupancy update; flush overrides both push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + ptr_t'(pop_n);
      tail  <= tail + ptr_t'(accept_n);
      count <= count + accept_n - cnt_t'(pop_n);
    end
  end

  // Sticky record of an icache return that did not fit; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (!flush && drop) begin
      overflow <= 1'b1;
    end
  end

  fetch_buffer_ram #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_ram (
    .clk    (clk),
    .we0    (we0),
    .we1    (we1),
    .waddr  (tail),
    .wdata0 (entry0),
    .wdata1 (entry1),
    .raddr0 (head),
    .raddr1 (head + ptr_t'(1)),
    .rdata0 (rd0),
    .rdata1 (rd1)
  );

  assign {out_inst0, out_pc0, out_cookie0, out_exc0, out_badv0} = rd0;
  assign {out_inst1, out_pc1, out_cookie1, out_exc1, out_badv1} = rd1;

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed scenarios plus randomized
// traffic, compared against a queue-based reference model.
module tb_fetch_buffer;

  localparam int DEPTH = 8;
  localparam int CW    = 32;
  localparam logic [31:0] NOP = 32'h0340_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [63:0]   in_data = '0;
  logic [31:0]   in_pc = '0;
  logic [CW-1:0] in_cookie = '0;
  logic [6:0]    in_exception = '0;
  logic [31:0]   in_badv = '0;
  logic          fetch_ready;
  logic [1:0]    out_valid;
  logic [31:0]   out_inst0, out_inst1, out_pc0, out_pc1;
  logic [CW-1:0] out_cookie0, out_cookie1;
  logic [6:0]    out_exc0, out_exc1;
  logic [31:0]   out_badv0, out_badv1;
  logic [1:0]    dec_pop = '0;
  logic          overflow;

  fetch_buffer #(.DEPTH(DEPTH), .COOKIE_WIDTH(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_pc        (in_pc),
    .in_cookie    (in_cookie),
    .in_exception (in_exception),
    .in_badv      (in_badv),
    .fetch_ready  (fetch_ready),
    .out_valid    (out_valid),
    .out_inst0    (out_inst0),
    .out_inst1    (out_inst1),
    .out_pc0      (out_pc0),
    .out_pc1      (out_pc1),
    .out_cookie0  (out_cookie0),
    .out_cookie1  (out_cookie1),
    .out_exc0     (out_exc0),
    .out_exc1     (out_exc1),
    .out_badv0    (out_badv0),
    .out_badv1    (out_badv1),
    .dec_pop      (dec_pop),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0]   inst;
    logic [31:0]   pc;
    logic [CW-1:0] cookie;
    logic [6:0]    exc;
    logic [31:0]   badv;
  } ent_t;

  ent_t mq[$];
  logic m_ovf = 1'b0;

  function automatic int m_avail();
    if (mq.size() == 0) return 0;
    if (mq.size() >= 2 && mq[0].exc == 7'd0) return 2;
    return 1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int av;
    av = m_avail();
    chk({tag, "_vld"}, 64'(out_valid), (av == 2) ? 64'd3 : (av == 1) ? 64'd1 : 64'd0);
    chk({tag, "_rdy"}, 64'(fetch_ready), 64'((DEPTH - mq.size()) >= 4));
    chk({tag, "_ovf"}, 64'(overflow), 64'(m_ovf));
    if (av >= 1) begin
      chk({tag, "_inst0"},   64'(out_inst0),   64'(mq[0].inst));
      chk({tag, "_pc0"},     64'(out_pc0),     64'(mq[0].pc));
      chk({tag, "_cookie0"}, 64'(out_cookie0), 64'(mq[0].cookie));
      chk({tag, "_exc0"},    64'(out_exc0),    64'(mq[0].exc));
      chk({tag, "_badv0"},   64'(out_badv0),   64'(mq[0].badv));
    end
    if (av == 2) begin
      chk({tag, "_inst1"},   64'(out_inst1),   64'(mq[1].inst));
      chk({tag, "_pc1"},     64'(out_pc1),     64'(mq[1].pc));
      chk({tag, "_cookie1"}, 64'(out_cookie1), 64'(mq[1].cookie));
      chk({tag, "_exc1"},    64'(out_exc1),    64'(mq[1].exc));
      chk({tag, "_badv1"},   64'(out_badv1),   64'(mq[1].badv));
    end
  endtask

  // One clock cycle: drive inputs, advance the model, clock, then check.
  task automatic step(input logic v, input logic [63:0] d, input logic [31:0] pc,
                      input logic [6:0] exc, input logic [31:0] badv,
                      input int pop, input logic fl, input string tag);
    ent_t nw[$];
    ent_t e;
    logic [CW-1:0] ck;
    int sz0, av, pe, space;
    ck = CW'($urandom);
    in_valid = v; in_data = d; in_pc = pc; in_cookie = ck;
    in_exception = exc; in_badv = badv; dec_pop = 2'(pop); flush = fl;
    sz0 = mq.size();
    av  = m_avail();
    pe  = (pop < av) ? pop : av;
    if (fl) begin
      mq.delete();
    end else begin
      e.cookie = ck; e.exc = exc; e.badv = badv;
      if (v) begin
        if (exc != 7'd0) begin
          e.inst = NOP; e.pc = pc; nw.push_back(e);
        end else if (pc[2]) begin
          e.inst = d[63:32]; e.pc = pc; nw.push_back(e);
        end else begin
          e.inst = d[31:0]; e.pc = pc; nw.push_back(e);
          e.inst = d[63:32]; e.pc = pc + 32'd4; nw.push_back(e);
        end
      end
      space = DEPTH - sz0;
      repeat (pe) void'(mq.pop_front());
      foreach (nw[i]) if (i < space) mq.push_back(nw[i]);
      if (nw.size() > space) m_ovf = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; dec_pop = 2'd0; flush = 1'b0; in_exception = '0;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    mq.delete();
    m_ovf = 1'b0;
    chk({tag, "_vld"}, 64'(out_valid), 64'd0);
    chk({tag, "_rdy"}, 64'(fetch_ready), 64'd1);
    chk({tag, "_ovf"}, 64'(overflow), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 12 && mq.size() > 0; k++)
      step(1'b0, '0, '0, '0, '0, 2, 1'b0, tag);
  endtask

  initial begin
    logic [31:0] base;
    logic        v;
    logic [6:0]  ex;

    #2 rst = 1'b1;
    #1;
    chk("rst_vld", 64'(out_valid), 64'd0);
    chk("rst_rdy", 64'(fetch_ready), 64'd1);
    chk("rst_ovf", 64'(overflow), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Aligned pair splits into two entries.
    step(1'b1, 64'h22222222_11111111, 32'h1C000000, '0, '0, 0, 1'b0, "t1");
    chk("t1_vld_c",  64'(out_valid), 64'd3);
    chk("t1_inst0_c", 64'(out_inst0), 64'h11111111);
    chk("t1_pc1_c",   64'(out_pc1),   64'h1C000004);
    step(1'b0, '0, '0, '0, '0, 2, 1'b0, "t1pop");

    // Fetch starting at the upper word yields one entry.
    step(1'b1, 64'hAAAAAAAA_BBBBBBBB, 32'h1C000004, '0, '0, 0, 1'b0, "t2");
    chk("t2_vld_c",   64'(out_valid), 64'd1);
    chk("t2_inst0_c", 64'(out_inst0), 64'hAAAAAAAA);
    step(1'b0, '0, '0, '0, '0, 1, 1'b0, "t2pop");

    // Faulting fetch issues alone as a NOP.
    step(1'b1, 64'h12345678_9ABCDEF0, 32'h1C000010, 7'h08, 32'h1C000010, 0, 1'b0, "t3a");
    step(1'b1, 64'h44444444_33333333, 32'h1C000018, '0, '0, 0, 1'b0, "t3b");
    chk("t3_vld_c",  64'(out_valid), 64'd1);
    chk("t3_inst0_c", 64'(out_inst0), 64'(NOP));
    chk("t3_exc0_c",  64'(out_exc0),  64'h08);
    step(1'b0, '0, '0, '0, '0, 1, 1'b0, "t3pop");
    chk("t3_pair_c", 64'(out_valid), 64'd3);
    drain("t3drain");

    // Randomized legal traffic: pushes only when the buffer grants credit.
    for (int c = 0; c < 400; c++) begin
      v  = fetch_ready && ($urandom_range(0, 3) != 0);
      ex = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(1, 127)) : 7'd0;
      step(v, {$urandom, $urandom}, {$urandom, 2'b00} >> 0, ex, $urandom,
           int'($urandom_range(0, 2)), ($urandom_range(0, 39) == 0), "rnd");
    end
    drain("rnddrain");

    // Wrap-around: park head/tail at the last slot, then stream pairs.
    do_reset("r5");
    for (int k = 0; k < 7; k++)
      step(1'b1, {$urandom, $urandom}, 32'h1C000204 + 32'(8 * k), '0, '0, 1, 1'b0, "t5pre");
    step(1'b0, '0, '0, '0, '0, 1, 1'b0, "t5pre");
    base = 32'h1C001000;
    for (int k = 0; k < 20; k++) begin
      step(1'b1, {$urandom, $urandom}, base + 32'(8 * k), '0, '0, 2, 1'b0, "t5");
      chk("t5_vld_c", 64'(out_valid), 64'd3);
      chk("t5_pc0_c", 64'(out_pc0), 64'(base + 32'(8 * k)));
      chk("t5_pc1_c", 64'(out_pc1), 64'(base + 32'(8 * k) + 32'd4));
    end
    drain("t5drain");

    // Credit threshold and overflow on a full buffer.
    for (int k = 0; k < 7; k++) begin
      step(1'b1, {$urandom, $urandom}, 32'h1C000304 + 32'(8 * k), '0, '0, 0, 1'b0, "t4");
      if (k == 3) chk("t4_rdy_at4", 64'(fetch_ready), 64'd1);
      if (k == 4) chk("t4_rdy_at5", 64'(fetch_ready), 64'd0);
    end
    step(1'b1, 64'h66666666_55555555, 32'h1C000400, '0, '0, 0, 1'b0, "t4ovf");
    chk("t4_ovf_c", 64'(overflow), 64'd1);
    drain("t4drain");
    chk("t4_ovf_sticky", 64'(overflow), 64'd1);

    // Flush beats a same-cycle push and pop; overflow survives it.
    for (int k = 0; k < 3; k++)
      step(1'b1, {$urandom, $urandom}, 32'h1C000500 + 32'(8 * k), '0, '0, 0, 1'b0, "t6fill");
    step(1'b1, {$urandom, $urandom}, 32'h1C000600, '0, '0, 2, 1'b1, "t6flush");
    chk("t6_vld_c", 64'(out_valid), 64'd0);
    chk("t6_rdy_c", 64'(fetch_ready), 64'd1);
    chk("t6_ovf_c", 64'(overflow), 64'd1);

    // Asynchronous reset mid-stream.
    step(1'b1, {$urandom, $urandom}, 32'h1C000700, '0, '0, 0, 1'b0, "t6pre");
    do_reset("t6rst");
    step(1'b1, 64'h88888888_77777777, 32'h1C000800, '0, '0, 0, 1'b0, "t6post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
